// File: rtl/axis_pkt_gen.sv
// AXI-stream packet generator: fixed-length packets with incrementing
// payload, rotating last-beat mty, idle gaps and periodic drop marking.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int MTY_WIDTH  = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int NUM_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [NUM_WIDTH-1:0]  cfg_pkt_num,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [MTY_WIDTH-1:0]  cfg_mty_base,
  input  logic [NUM_WIDTH-1:0]  cfg_drop_every,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
  input  logic                  m_axis_tready,
  output logic                  drop_incmpt_pkt,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_WIDTH-1:0]  pkt_sent,
  output logic [31:0]           beat_sent
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP
  } state_t;

  state_t                state_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  beat_idx_q;
  logic [NUM_WIDTH-1:0]  num_q;
  logic [NUM_WIDTH-1:0]  de_q;
  logic [NUM_WIDTH-1:0]  drop_cnt_q;
  logic [NUM_WIDTH-1:0]  pkt_sent_q;
  logic [GAP_WIDTH-1:0]  gap_q;
  logic [GAP_WIDTH-1:0]  gap_cnt_q;
  logic [MTY_WIDTH-1:0]  pkt_mty_q;
  logic                  tvalid_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tlast_q;
  logic [MTY_WIDTH-1:0]  tmty_q;
  logic                  drop_q;
  logic                  busy_q;
  logic                  done_q;
  logic [31:0]           beat_sent_q;

  logic [LEN_WIDTH-1:0]  len_in;
  logic                  xfer;
  logic                  run_end;
  logic [MTY_WIDTH-1:0]  mty_inc;
  logic [NUM_WIDTH-1:0]  dcnt_inc;
  logic [LEN_WIDTH-1:0]  sel_idx_d;
  logic [LEN_WIDTH-1:0]  sel_len_d;
  logic [MTY_WIDTH-1:0]  sel_mty_d;
  logic [NUM_WIDTH-1:0]  sel_dcnt_d;
  logic [NUM_WIDTH-1:0]  sel_de_d;
  logic                  nb_last_d;
  logic [DATA_WIDTH-1:0] nb_data_d;
  logic [MTY_WIDTH-1:0]  nb_mty_d;
  logic                  nb_drop_d;

  assign len_in   = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
  assign xfer     = tvalid_q & m_axis_tready;
  assign mty_inc  = pkt_mty_q + 1'b1;
  assign dcnt_inc = (drop_cnt_q == de_q - 1'b1) ? '0
                  : drop_cnt_q + 1'b1;
  assign run_end  = ((num_q != '0) &&
                     (pkt_sent_q + 1'b1 == num_q)) || stop;

  // Select the packet context of the beat presented after this edge
  always_comb begin
    sel_idx_d  = beat_idx_q + 1'b1;
    sel_len_d  = len_q;
    sel_mty_d  = pkt_mty_q;
    sel_dcnt_d = drop_cnt_q;
    sel_de_d   = de_q;
    unique case (state_q)
      S_IDLE: begin
        sel_idx_d  = '0;
        sel_len_d  = len_in;
        sel_mty_d  = cfg_mty_base;
        sel_dcnt_d = '0;
        sel_de_d   = cfg_drop_every;
      end
      S_GAP: begin
        sel_idx_d = '0;
      end
      S_SEND: begin
        if (tlast_q) begin
          sel_idx_d  = '0;
          sel_mty_d  = mty_inc;
          sel_dcnt_d = dcnt_inc;
        end
      end
      default: begin
        sel_idx_d = '0;
      end
    endcase
  end

  assign nb_last_d = (sel_idx_d == sel_len_d - 1'b1);
  assign nb_data_d = DATA_WIDTH'(sel_idx_d + 1'b1);
  assign nb_mty_d  = nb_last_d ? sel_mty_d : '0;
  assign nb_drop_d = nb_last_d && (sel_de_d != '0) &&
                     (sel_dcnt_d == sel_de_d - 1'b1);

  // Run FSM with registered stream, status and counter outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      beat_idx_q  <= '0;
      num_q       <= '0;
      de_q        <= '0;
      drop_cnt_q  <= '0;
      pkt_sent_q  <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      pkt_mty_q   <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      tmty_q      <= '0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      beat_sent_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q       <= len_in;
            num_q       <= cfg_pkt_num;
            gap_q       <= cfg_gap;
            pkt_mty_q   <= cfg_mty_base;
            de_q        <= cfg_drop_every;
            drop_cnt_q  <= '0;
            pkt_sent_q  <= '0;
            beat_sent_q <= '0;
            busy_q      <= 1'b1;
            beat_idx_q  <= sel_idx_d;
            tvalid_q    <= 1'b1;
            tdata_q     <= nb_data_d;
            tlast_q     <= nb_last_d;
            tmty_q      <= nb_mty_d;
            drop_q      <= nb_drop_d;
            state_q     <= S_SEND;
          end
        end
        S_SEND: begin
          if (xfer) begin
            beat_sent_q <= beat_sent_q + 1'b1;
            if (tlast_q) begin
              pkt_sent_q <= pkt_sent_q + 1'b1;
              pkt_mty_q  <= mty_inc;
              drop_cnt_q <= dcnt_inc;
              if (run_end) begin
                tvalid_q <= 1'b0;
                tdata_q  <= '0;
                tlast_q  <= 1'b0;
                tmty_q   <= '0;
                drop_q   <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_IDLE;
              end else if (gap_q == '0) begin
                beat_idx_q <= sel_idx_d;
                tdata_q    <= nb_data_d;
                tlast_q    <= nb_last_d;
                tmty_q     <= nb_mty_d;
                drop_q     <= nb_drop_d;
              end else begin
                tvalid_q  <= 1'b0;
                tdata_q   <= '0;
                tlast_q   <= 1'b0;
                tmty_q    <= '0;
                drop_q    <= 1'b0;
                gap_cnt_q <= gap_q - 1'b1;
                state_q   <= S_GAP;
              end
            end else begin
              beat_idx_q <= sel_idx_d;
              tdata_q    <= nb_data_d;
              tlast_q    <= nb_last_d;
              tmty_q     <= nb_mty_d;
              drop_q     <= nb_drop_d;
            end
          end
        end
        S_GAP: begin
          if (stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (gap_cnt_q == '0) begin
            beat_idx_q <= sel_idx_d;
            tvalid_q   <= 1'b1;
            tdata_q    <= nb_data_d;
            tlast_q    <= nb_last_d;
            tmty_q     <= nb_mty_d;
            drop_q     <= nb_drop_d;
            state_q    <= S_SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tdata     = tdata_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tuser_mty = tmty_q;
  assign drop_incmpt_pkt  = drop_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pkt_sent         = pkt_sent_q;
  assign beat_sent        = beat_sent_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Testbench for axis_pkt_gen: table of runs checked beat by beat,
// plus hand-written reset-mid-packet sequence.
module tb_axis_pkt_gen;

  logic        aclk = 1'b0;
  logic        areset;
  logic        start;
  logic        stop;
  logic [15:0] cfg_pkt_len;
  logic [15:0] cfg_pkt_num;
  logic [7:0]  cfg_gap;
  logic [7:0]  cfg_mty_base;
  logic [15:0] cfg_drop_every;
  logic        tvalid;
  logic [7:0]  tdata;
  logic        tlast;
  logic [7:0]  tmty;
  logic        tready;
  logic        drop;
  logic        busy;
  logic        done;
  logic [15:0] pkt_sent;
  logic [31:0] beat_sent;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_pkt_gen dut (
    .aclk             (aclk),
    .areset           (areset),
    .start            (start),
    .stop             (stop),
    .cfg_pkt_len      (cfg_pkt_len),
    .cfg_pkt_num      (cfg_pkt_num),
    .cfg_gap          (cfg_gap),
    .cfg_mty_base     (cfg_mty_base),
    .cfg_drop_every   (cfg_drop_every),
    .m_axis_tvalid    (tvalid),
    .m_axis_tdata     (tdata),
    .m_axis_tlast     (tlast),
    .m_axis_tuser_mty (tmty),
    .m_axis_tready    (tready),
    .drop_incmpt_pkt  (drop),
    .busy             (busy),
    .done             (done),
    .pkt_sent         (pkt_sent),
    .beat_sent        (beat_sent)
  );

  typedef struct {
    int len;
    int num;
    int gap;
    int mty;
    int de;
    int tog;
    int stop_k;
    int stop_b;
    int xstart;
    int exp_pkts;
    int exp_beats;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int k = 0;
    int b = 0;
    int idle = 0;
    int cyc = 0;
    int len_eff;
    bit seen_last = 0;
    bit hold = 0;
    bit ok = 0;
    logic [7:0] h_data;
    logic       h_last;
    logic [7:0] h_mty;
    logic       h_drop;
    int exp_last;
    int exp_drop;
    len_eff = (v.len == 0) ? 1 : v.len;
    @(negedge aclk);
    cfg_pkt_len    = 16'(v.len);
    cfg_pkt_num    = 16'(v.num);
    cfg_gap        = 8'(v.gap);
    cfg_mty_base   = 8'(v.mty);
    cfg_drop_every = 16'(v.de);
    stop   = 1'b0;
    tready = 1'b1;
    start  = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    chk($sformatf("v%0d first_tvalid", id), 32'(tvalid), 1);
    chk($sformatf("v%0d busy", id), 32'(busy), 1);
    chk($sformatf("v%0d pkt_sent_clr", id), 32'(pkt_sent), 0);
    chk($sformatf("v%0d beat_sent_clr", id), beat_sent, 0);
    while (1) begin
      if (cyc > 0) @(negedge aclk);
      cyc++;
      if (done) begin
        ok = 1;
        break;
      end
      if (cyc > 3000) break;
      start = (v.xstart != 0 && cyc == v.xstart);
      if (hold) begin
        chk($sformatf("v%0d hold_valid", id), 32'(tvalid), 1);
        chk($sformatf("v%0d hold_data", id), 32'(tdata), 32'(h_data));
        chk($sformatf("v%0d hold_last", id), 32'(tlast), 32'(h_last));
        chk($sformatf("v%0d hold_mty", id), 32'(tmty), 32'(h_mty));
        chk($sformatf("v%0d hold_drop", id), 32'(drop), 32'(h_drop));
      end
      tready = (v.tog != 0) ? (cyc % 2 == 1) : 1'b1;
      if (tvalid) begin
        if (seen_last) begin
          chk($sformatf("v%0d gap_len", id), idle, v.gap);
          seen_last = 0;
        end
        if (k == v.stop_k && b == v.stop_b) stop = 1'b1;
        if (tready) begin
          exp_last = (b == len_eff - 1) ? 1 : 0;
          exp_drop = (exp_last == 1 && v.de != 0 &&
                      ((k + 1) % v.de) == 0) ? 1 : 0;
          chk($sformatf("v%0d k%0d b%0d tdata", id, k, b),
              32'(tdata), (b + 1) % 256);
          chk($sformatf("v%0d k%0d b%0d tlast", id, k, b),
              32'(tlast), exp_last);
          chk($sformatf("v%0d k%0d b%0d mty", id, k, b), 32'(tmty),
              (exp_last == 1) ? (v.mty + k) % 256 : 0);
          chk($sformatf("v%0d k%0d b%0d drop", id, k, b),
              32'(drop), exp_drop);
          b++;
          if (exp_last == 1) begin
            b = 0;
            k++;
            seen_last = 1;
            idle = 0;
          end
        end
        hold   = !tready;
        h_data = tdata;
        h_last = tlast;
        h_mty  = tmty;
        h_drop = drop;
      end else begin
        hold = 0;
        if (seen_last) idle++;
      end
    end
    start = 1'b0;
    stop  = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL v%0d done_timeout: got no done expected done", id);
    end
    chk($sformatf("v%0d end_busy", id), 32'(busy), 0);
    chk($sformatf("v%0d end_tvalid", id), 32'(tvalid), 0);
    chk($sformatf("v%0d pkt_sent", id), 32'(pkt_sent), v.exp_pkts);
    chk($sformatf("v%0d beat_sent", id), beat_sent, v.exp_beats);
    @(negedge aclk);
    chk($sformatf("v%0d done_once", id), 32'(done), 0);
    chk($sformatf("v%0d idle_tvalid", id), 32'(tvalid), 0);
    chk($sformatf("v%0d hold_pkt_sent", id), 32'(pkt_sent), v.exp_pkts);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tvalid"}, 32'(tvalid), 0);
    chk({tag, " tdata"}, 32'(tdata), 0);
    chk({tag, " tlast"}, 32'(tlast), 0);
    chk({tag, " mty"}, 32'(tmty), 0);
    chk({tag, " drop"}, 32'(drop), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pkt_sent"}, 32'(pkt_sent), 0);
    chk({tag, " beat_sent"}, beat_sent, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{13, 1, 0, 8'h01, 0, 0, -1, -1, 0, 1, 13};
    vecs[1] = '{13, 4, 0, 8'h02, 3, 0, -1, -1, 0, 4, 52};
    vecs[2] = '{4, 2, 5, 8'h00, 0, 1, -1, -1, 0, 2, 8};
    vecs[3] = '{3, 0, 1, 8'hFE, 2, 0, 5, 1, 0, 6, 18};
    vecs[4] = '{0, 3, 2, 8'h07, 1, 0, -1, -1, 0, 3, 3};
    vecs[5] = '{13, 4, 0, 8'h02, 3, 0, -1, -1, 10, 4, 52};

    areset         = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    tready         = 1'b1;
    cfg_pkt_len    = '0;
    cfg_pkt_num    = '0;
    cfg_gap        = '0;
    cfg_mty_base   = '0;
    cfg_drop_every = '0;
    repeat (3) @(negedge aclk);
    chk_all_zero("reset");
    areset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    @(negedge aclk);
    cfg_pkt_len    = 16'd13;
    cfg_pkt_num    = 16'd1;
    cfg_gap        = 8'd0;
    cfg_mty_base   = 8'd1;
    cfg_drop_every = 16'd0;
    tready         = 1'b1;
    start          = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    n = 0;
    while (!(tvalid && tdata == 8'd5) && n < 50) begin
      @(negedge aclk);
      n++;
    end
    chk("midrst beat5", 32'(tdata), 5);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk_all_zero("midrst");
    @(negedge aclk);
    chk("midrst stay_idle", 32'(tvalid), 0);
    chk("midrst no_busy", 32'(busy), 0);

    run_vec(6, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
